// File: rtl/vxe_cu_vpu_fwd_xbar.sv
// vxe_cu_vpu_fwd_xbar: routes control-unit VPU commands by destination mask into per-channel FIFOs.
// Latency: a write accepted at edge N is presented on its channel bus after edge N+1.
// Backpressure: o_fwd_vpu_rdy drops while any channel FIFO is full, during flush and during reset.
//
// Ports:
//   clk, rst               rising-edge clock, synchronous active-high reset
//   i_flush                empties every channel FIFO; presented commands are kept
//   o_fwd_vpu_rdy          forwarding interface can take a write this cycle
//   i_fwd_vpu_wr/dst/op/th/pl  write strobe, channel mask and command fields
//   o_vpu_cmd_sel/i_vpu_cmd_ack  per-channel valid / accept
//   o_vpu_cmd_op/th/pl     per-channel command buses, channel c at [c*W +: W]
//   o_chan_active          channel c has queued or presented work
//   o_pipes_active         OR of o_chan_active

// Channel FIFO: power-of-two ring with one extra pointer bit for full/empty.
// Latency: a push is visible at the head the cycle after its edge.
// Backpressure: none internally; the owner must not push while full.
module vxe_cu_vpu_fwd_xbar_fifo #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push_vld,
    input  logic [DW-1:0] push_dat,
    input  logic          pop,
    output logic [DW-1:0] head_dat,
    output logic          full,
    output logic          empty
);
    localparam int DEPTH = 1 << AW;

    logic [AW:0]   wr_ptr_q;
    logic [AW:0]   wr_ptr_d;
    logic [AW:0]   rd_ptr_q;
    logic [AW:0]   rd_ptr_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];

    // Pointers equal: empty.  Same slot but opposite lap: full.
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                      (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign head_dat = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (push_vld) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_dat;
            wr_ptr_d                = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        end
        // Flush discards everything queued up to (but not including) a
        // push on the same edge; the owner never pushes during flush.
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
        end else if (pop) begin
            rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end
endmodule

module vxe_cu_vpu_fwd_xbar #(
    parameter int NCH        = 2,
    parameter int DEPTH_POW2 = 4,
    parameter int OP_W       = 5,
    parameter int TH_W       = 3,
    parameter int PL_W       = 48
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_flush,
    output logic                 o_fwd_vpu_rdy,
    input  logic                 i_fwd_vpu_wr,
    input  logic [NCH-1:0]       i_fwd_vpu_dst,
    input  logic [OP_W-1:0]      i_fwd_vpu_op,
    input  logic [TH_W-1:0]      i_fwd_vpu_th,
    input  logic [PL_W-1:0]      i_fwd_vpu_pl,
    output logic [NCH-1:0]       o_vpu_cmd_sel,
    input  logic [NCH-1:0]       i_vpu_cmd_ack,
    output logic [NCH*OP_W-1:0]  o_vpu_cmd_op,
    output logic [NCH*TH_W-1:0]  o_vpu_cmd_th,
    output logic [NCH*PL_W-1:0]  o_vpu_cmd_pl,
    output logic [NCH-1:0]       o_chan_active,
    output logic                 o_pipes_active
);
    typedef struct packed {
        logic [OP_W-1:0] op;
        logic [TH_W-1:0] th;
        logic [PL_W-1:0] pl;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ISSUE = 1'b1;

    logic [NCH-1:0] fifo_full;
    logic [NCH-1:0] fifo_empty;
    logic [NCH-1:0] push_vld;
    logic           wr_acc;
    cmd_t           wr_cmd;

    // Ready depends only on reset, flush and FIFO state, never on the
    // destination mask, so the upstream has no combinational loop through
    // dst/data.  Any full channel stalls every write.
    assign o_fwd_vpu_rdy = !rst && !i_flush && !(|fifo_full);
    assign wr_acc        = i_fwd_vpu_wr && o_fwd_vpu_rdy;
    assign wr_cmd        = {i_fwd_vpu_op, i_fwd_vpu_th, i_fwd_vpu_pl};

    // Broadcast is atomic: every selected channel pushes on the same edge.
    // An all-zero mask is accepted and simply lands nowhere.
    assign push_vld = i_fwd_vpu_dst & {NCH{wr_acc}};

    genvar c;
    generate
        for (c = 0; c < NCH; c++) begin : g_ch
            cmd_t       head_dat;
            cmd_t       cmd_q;
            cmd_t       cmd_d;
            logic [0:0] state_q;
            logic [0:0] state_d;
            logic       pop;
            logic       avail;

            vxe_cu_vpu_fwd_xbar_fifo #(
                .DW (CMD_W),
                .AW (DEPTH_POW2)
            ) u_fifo (
                .clk      (clk),
                .rst      (rst),
                .flush    (i_flush),
                .push_vld (push_vld[c]),
                .push_dat (wr_cmd),
                .pop      (pop),
                .head_dat (head_dat),
                .full     (fifo_full[c]),
                .empty    (fifo_empty[c])
            );

            // Flush wins over a load: on a flush edge nothing new is
            // presented, so only commands already on the bus survive.
            assign avail = !fifo_empty[c] && !i_flush;

            always_comb begin
                state_d = state_q;
                cmd_d   = cmd_q;
                pop     = 1'b0;
                if (state_q == ST_IDLE) begin
                    if (avail) begin
                        cmd_d   = head_dat;
                        pop     = 1'b1;
                        state_d = ST_ISSUE;
                    end
                end else begin
                    // Without ack the bus is frozen.  With ack either the
                    // next head follows immediately or the channel idles;
                    // the bus keeps its last value while idle.
                    if (i_vpu_cmd_ack[c]) begin
                        if (avail) begin
                            cmd_d = head_dat;
                            pop   = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    state_q <= ST_IDLE;
                    cmd_q   <= '0;
                end else begin
                    state_q <= state_d;
                    cmd_q   <= cmd_d;
                end
            end

            assign o_vpu_cmd_sel[c]               = (state_q == ST_ISSUE);
            assign o_vpu_cmd_op[c*OP_W +: OP_W]   = cmd_q.op;
            assign o_vpu_cmd_th[c*TH_W +: TH_W]   = cmd_q.th;
            assign o_vpu_cmd_pl[c*PL_W +: PL_W]   = cmd_q.pl;
            assign o_chan_active[c]               = !fifo_empty[c] || (state_q == ST_ISSUE);
        end
    endgenerate

    assign o_pipes_active = |o_chan_active;
endmodule

// File: tb/tb_vxe_cu_vpu_fwd_xbar.sv
// Bench for vxe_cu_vpu_fwd_xbar with two channels and four-deep FIFOs.
// Latency: the reference model predicts presentation one cycle after acceptance.
// Backpressure: the model derives ready from its own per-channel occupancy.
module tb_vxe_cu_vpu_fwd_xbar;
    localparam int NCH   = 2;
    localparam int DP    = 2;
    localparam int OP_W  = 5;
    localparam int TH_W  = 3;
    localparam int PL_W  = 48;
    localparam int DEPTH = 1 << DP;
    localparam int CW    = OP_W + TH_W + PL_W;

    logic                clk = 1'b0;
    logic                rst;
    logic                i_flush;
    logic                o_fwd_vpu_rdy;
    logic                i_fwd_vpu_wr;
    logic [NCH-1:0]      i_fwd_vpu_dst;
    logic [CW-1:0]       cmd_in;
    logic [NCH-1:0]      o_vpu_cmd_sel;
    logic [NCH-1:0]      i_vpu_cmd_ack;
    logic [NCH*OP_W-1:0] o_vpu_cmd_op;
    logic [NCH*TH_W-1:0] o_vpu_cmd_th;
    logic [NCH*PL_W-1:0] o_vpu_cmd_pl;
    logic [NCH-1:0]      o_chan_active;
    logic                o_pipes_active;

    always #5 clk = ~clk;

    vxe_cu_vpu_fwd_xbar #(
        .NCH(NCH), .DEPTH_POW2(DP), .OP_W(OP_W), .TH_W(TH_W), .PL_W(PL_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_flush        (i_flush),
        .o_fwd_vpu_rdy  (o_fwd_vpu_rdy),
        .i_fwd_vpu_wr   (i_fwd_vpu_wr),
        .i_fwd_vpu_dst  (i_fwd_vpu_dst),
        .i_fwd_vpu_op   (cmd_in[CW-1 -: OP_W]),
        .i_fwd_vpu_th   (cmd_in[PL_W +: TH_W]),
        .i_fwd_vpu_pl   (cmd_in[PL_W-1:0]),
        .o_vpu_cmd_sel  (o_vpu_cmd_sel),
        .i_vpu_cmd_ack  (i_vpu_cmd_ack),
        .o_vpu_cmd_op   (o_vpu_cmd_op),
        .o_vpu_cmd_th   (o_vpu_cmd_th),
        .o_vpu_cmd_pl   (o_vpu_cmd_pl),
        .o_chan_active  (o_chan_active),
        .o_pipes_active (o_pipes_active)
    );

    int errs   = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: per channel, the commands waiting in the FIFO and
    // the one (if any) currently offered to the VPU.
    logic [CW-1:0] mq   [NCH][$];
    logic          pres_vld [NCH];
    logic [CW-1:0] pres [NCH];
    logic [CW-1:0] got  [NCH][$];
    logic [CW-1:0] sent [NCH][$];

    function automatic logic [CW-1:0] dut_cmd(int c);
        return {o_vpu_cmd_op[c*OP_W +: OP_W], o_vpu_cmd_th[c*TH_W +: TH_W],
                o_vpu_cmd_pl[c*PL_W +: PL_W]};
    endfunction

    function automatic logic [CW-1:0] rand_cmd();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[CW-1:0];
    endfunction

    function automatic logic [NCH-1:0] m_sel();
        logic [NCH-1:0] v;
        for (int c = 0; c < NCH; c++) v[c] = pres_vld[c];
        return v;
    endfunction

    function automatic logic [NCH-1:0] m_act();
        logic [NCH-1:0] v;
        for (int c = 0; c < NCH; c++) v[c] = pres_vld[c] || (mq[c].size() > 0);
        return v;
    endfunction

    function automatic logic m_rdy();
        logic r;
        r = !rst && !i_flush;
        for (int c = 0; c < NCH; c++) if (mq[c].size() >= DEPTH) r = 1'b0;
        return r;
    endfunction

    // Advance one clock: log DUT handshakes, update the model, then move
    // to just after the next rising edge.
    task automatic step();
        logic acc;
        acc = i_fwd_vpu_wr && m_rdy();
        for (int c = 0; c < NCH; c++)
            if (o_vpu_cmd_sel[c] && i_vpu_cmd_ack[c]) got[c].push_back(dut_cmd(c));
        for (int c = 0; c < NCH; c++) begin
            if (rst) begin
                mq[c].delete();
                pres_vld[c] = 1'b0;
            end else begin
                if (pres_vld[c] && i_vpu_cmd_ack[c]) pres_vld[c] = 1'b0;
                if (i_flush) begin
                    mq[c].delete();
                end else if (!pres_vld[c] && mq[c].size() > 0) begin
                    pres[c]     = mq[c].pop_front();
                    pres_vld[c] = 1'b1;
                end
                if (acc && i_fwd_vpu_dst[c]) begin
                    mq[c].push_back(cmd_in);
                    sent[c].push_back(cmd_in);
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_logs();
        for (int c = 0; c < NCH; c++) begin
            got[c].delete();
            sent[c].delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; i_fwd_vpu_wr = 1'b1; i_fwd_vpu_dst = 2'b11;
        cmd_in = rand_cmd(); i_vpu_cmd_ack = 2'b11;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (o_vpu_cmd_sel !== '0) begin
                errs++; $display("FAIL rst_sel got=%b want=00", o_vpu_cmd_sel);
            end
            checks++;
            if ({o_vpu_cmd_op, o_vpu_cmd_th, o_vpu_cmd_pl} !== '0) begin
                errs++; $display("FAIL rst_bus got op=%h th=%h pl=%h want 0", o_vpu_cmd_op, o_vpu_cmd_th, o_vpu_cmd_pl);
            end
            checks++;
            if (o_fwd_vpu_rdy !== 1'b0) begin
                errs++; $display("FAIL rst_rdy got=%b want=0", o_fwd_vpu_rdy);
            end
            checks++;
            if (o_pipes_active !== 1'b0) begin
                errs++; $display("FAIL rst_active got=%b want=0", o_pipes_active);
            end
        end
        rst = 1'b0; i_fwd_vpu_wr = 1'b0; i_vpu_cmd_ack = '0;
        step();
        checks++;
        if (o_fwd_vpu_rdy !== 1'b1) begin
            errs++; $display("FAIL rst_release_rdy got=%b want=1", o_fwd_vpu_rdy);
        end
        checks++;
        if (o_pipes_active !== 1'b0 || o_chan_active !== '0 || o_vpu_cmd_sel !== '0) begin
            errs++; $display("FAIL rst_release_idle got act=%b chan=%b sel=%b want 0", o_pipes_active, o_chan_active, o_vpu_cmd_sel);
        end
    endtask

    task automatic test_single_route();
        logic [CW-1:0] exp_cmd;
        clear_logs();
        exp_cmd = {5'h03, 3'd2, 48'hA5};
        cmd_in = exp_cmd; i_fwd_vpu_dst = 2'b10; i_fwd_vpu_wr = 1'b1; i_vpu_cmd_ack = 2'b10;
        step();
        i_fwd_vpu_wr = 1'b0;
        checks++;
        if (o_vpu_cmd_sel !== 2'b00) begin
            errs++; $display("FAIL single_in_fifo got sel=%b want=00", o_vpu_cmd_sel);
        end
        step();
        checks++;
        if (o_vpu_cmd_sel !== 2'b10 || dut_cmd(1) !== exp_cmd) begin
            errs++; $display("FAIL single_present got sel=%b cmd=%h want sel=10 cmd=%h", o_vpu_cmd_sel, dut_cmd(1), exp_cmd);
        end
        step();
        checks++;
        if (o_vpu_cmd_sel !== 2'b00) begin
            errs++; $display("FAIL single_one_cycle got sel=%b want=00", o_vpu_cmd_sel);
        end
        // A zero destination mask is accepted and goes nowhere.
        cmd_in = rand_cmd(); i_fwd_vpu_dst = 2'b00; i_fwd_vpu_wr = 1'b1;
        #1;
        checks++;
        if (o_fwd_vpu_rdy !== 1'b1) begin
            errs++; $display("FAIL dst0_rdy got=%b want=1", o_fwd_vpu_rdy);
        end
        step();
        i_fwd_vpu_wr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (o_vpu_cmd_sel !== 2'b00 || o_pipes_active !== 1'b0) begin
                errs++; $display("FAIL dst0_idle got sel=%b act=%b want 00/0", o_vpu_cmd_sel, o_pipes_active);
            end
        end
        checks++;
        if (got[0].size() != 0 || got[1].size() != 1) begin
            errs++; $display("FAIL single_count got ch0=%0d ch1=%0d want 0/1", got[0].size(), got[1].size());
        end else begin
            checks++;
            if (got[1][0] !== exp_cmd) begin
                errs++; $display("FAIL single_data got=%h want=%h", got[1][0], exp_cmd);
            end
        end
    endtask

    task automatic test_broadcast_backpressure();
        clear_logs();
        i_vpu_cmd_ack = 2'b01; i_fwd_vpu_dst = 2'b11;
        for (int i = 0; i < 7; i++) begin
            i_fwd_vpu_wr = (i < 3);
            cmd_in = rand_cmd();
            step();
            checks++;
            if (o_vpu_cmd_sel !== m_sel()) begin
                errs++; $display("FAIL bcast_sel cyc=%0d got=%b want=%b", cyc, o_vpu_cmd_sel, m_sel());
            end
            for (int c = 0; c < NCH; c++) if (pres_vld[c]) begin
                checks++;
                if (dut_cmd(c) !== pres[c]) begin
                    errs++; $display("FAIL bcast_bus ch=%0d got=%h want=%h", c, dut_cmd(c), pres[c]);
                end
            end
        end
        i_fwd_vpu_wr = 1'b0;
        checks++;
        if (got[0].size() != 3 || got[1].size() != 0) begin
            errs++; $display("FAIL bcast_hold got ch0=%0d ch1=%0d want 3/0", got[0].size(), got[1].size());
        end
        i_vpu_cmd_ack = 2'b11;
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (got[1].size() != 3 || o_vpu_cmd_sel !== 2'b00) begin
            errs++; $display("FAIL bcast_release got ch1=%0d sel=%b want 3/00", got[1].size(), o_vpu_cmd_sel);
        end
        for (int c = 0; c < NCH; c++) begin
            checks++;
            if (got[c] != sent[c]) begin
                errs++; $display("FAIL bcast_order ch=%0d got=%0d items want=%0d items in order", c, got[c].size(), sent[c].size());
            end
        end
    endtask

    task automatic test_full();
        clear_logs();
        i_vpu_cmd_ack = 2'b00; i_fwd_vpu_dst = 2'b01;
        for (int i = 0; i < 6; i++) begin
            i_fwd_vpu_wr = 1'b1; cmd_in = rand_cmd();
            #1;
            checks++;
            if (o_fwd_vpu_rdy !== (i < 5)) begin
                errs++; $display("FAIL full_rdy write=%0d got=%b want=%b", i, o_fwd_vpu_rdy, (i < 5));
            end
            step();
        end
        i_fwd_vpu_wr = 1'b0;
        checks++;
        if (o_fwd_vpu_rdy !== 1'b0) begin
            errs++; $display("FAIL full_stays got rdy=%b want=0", o_fwd_vpu_rdy);
        end
        i_vpu_cmd_ack = 2'b01;
        step();
        checks++;
        if (o_fwd_vpu_rdy !== 1'b1) begin
            errs++; $display("FAIL full_after_pop got rdy=%b want=1", o_fwd_vpu_rdy);
        end
        for (int i = 0; i < 6; i++) step();
        checks++;
        if (got[0].size() != 5 || got[0] != sent[0] || o_chan_active !== 2'b00) begin
            errs++; $display("FAIL full_drain got n=%0d act=%b want 5 in order, act=00", got[0].size(), o_chan_active);
        end
    endtask

    task automatic test_flush();
        clear_logs();
        i_vpu_cmd_ack = 2'b00; i_fwd_vpu_dst = 2'b01;
        for (int i = 0; i < 5; i++) begin
            i_fwd_vpu_wr = (i < 4); cmd_in = rand_cmd();
            step();
        end
        i_flush = 1'b1; i_fwd_vpu_wr = 1'b1; cmd_in = rand_cmd();
        #1;
        checks++;
        if (o_fwd_vpu_rdy !== 1'b0) begin
            errs++; $display("FAIL flush_rdy got=%b want=0", o_fwd_vpu_rdy);
        end
        step();
        i_flush = 1'b0; i_fwd_vpu_wr = 1'b0;
        checks++;
        if (o_vpu_cmd_sel !== 2'b01 || dut_cmd(0) !== sent[0][0] || o_chan_active !== 2'b01) begin
            errs++; $display("FAIL flush_keep got sel=%b cmd=%h act=%b want 01/%h/01", o_vpu_cmd_sel, dut_cmd(0), o_chan_active, sent[0][0]);
        end
        i_vpu_cmd_ack = 2'b01;
        step();
        checks++;
        if (o_vpu_cmd_sel !== 2'b00 || o_chan_active !== 2'b00) begin
            errs++; $display("FAIL flush_drop got sel=%b act=%b want 00/00", o_vpu_cmd_sel, o_chan_active);
        end
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (got[0].size() != 1 || got[0][0] !== sent[0][0] || o_pipes_active !== 1'b0) begin
            errs++; $display("FAIL flush_count got n=%0d act=%b want 1 delivered, idle", got[0].size(), o_pipes_active);
        end
    endtask

    task automatic test_wrap();
        int  n;
        int  total;
        logic acc_now;
        clear_logs();
        n = 0;
        total = 3 * DEPTH + 3;
        for (int t = 0; t < 600 && (n < total || m_act() != '0); t++) begin
            i_vpu_cmd_ack = 2'($urandom_range(0, 3));
            if (n < total && $urandom_range(0, 3) != 0) begin
                i_fwd_vpu_wr = 1'b1;
                i_fwd_vpu_dst = {1'($urandom_range(0, 1)), 1'b1};
                cmd_in = rand_cmd();
            end else begin
                i_fwd_vpu_wr = 1'b0;
            end
            #1;
            checks++;
            if (o_fwd_vpu_rdy !== m_rdy()) begin
                errs++; $display("FAIL wrap_rdy cyc=%0d got=%b want=%b", cyc, o_fwd_vpu_rdy, m_rdy());
            end
            acc_now = i_fwd_vpu_wr && m_rdy();
            step();
            if (acc_now) n++;
            checks++;
            if (o_vpu_cmd_sel !== m_sel() || o_chan_active !== m_act()) begin
                errs++; $display("FAIL wrap_sel cyc=%0d got sel=%b act=%b want sel=%b act=%b", cyc, o_vpu_cmd_sel, o_chan_active, m_sel(), m_act());
            end
            for (int c = 0; c < NCH; c++) if (pres_vld[c]) begin
                checks++;
                if (dut_cmd(c) !== pres[c]) begin
                    errs++; $display("FAIL wrap_bus ch=%0d cyc=%0d got=%h want=%h", c, cyc, dut_cmd(c), pres[c]);
                end
            end
        end
        i_fwd_vpu_wr = 1'b0;
        checks++;
        if (n != total || o_pipes_active !== 1'b0) begin
            errs++; $display("FAIL wrap_done got accepted=%0d active=%b want %0d/0", n, o_pipes_active, total);
        end
        for (int c = 0; c < NCH; c++) begin
            checks++;
            if (got[c] != sent[c]) begin
                errs++; $display("FAIL wrap_order ch=%0d got=%0d items want=%0d items in order", c, got[c].size(), sent[c].size());
            end
        end
    endtask

    initial begin
        rst = 1'b1; i_flush = 1'b0; i_fwd_vpu_wr = 1'b0; i_fwd_vpu_dst = '0;
        cmd_in = '0; i_vpu_cmd_ack = '0;
        for (int c = 0; c < NCH; c++) begin
            pres_vld[c] = 1'b0;
            pres[c]     = '0;
        end
        test_reset();
        test_single_route();
        test_broadcast_backpressure();
        test_full();
        test_flush();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1);
    end
endmodule
